// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I/D main-memory arbiter.
// Default widths match the system memory address and cache line widths.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_MEM_WAIT = 2'd1,
        ARB_DELIVER  = 2'd2
    } arb_state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between the I and D miss paths.
// MEM_ARB_RR_EN: ties alternate against last_owner; otherwise D has fixed priority.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic i_ireq,
    input  logic i_dreq,
    input  logic i_last_owner,
    output logic o_vld,
    output logic o_owner
);

    always_comb begin
        o_vld   = i_ireq | i_dreq;
        o_owner = i_dreq ? OWNER_D : OWNER_I;
`ifdef MEM_ARB_RR_EN
        if (i_ireq && i_dreq)
            o_owner = (i_last_owner == OWNER_I) ? OWNER_D : OWNER_I;
`endif
    end

`ifndef MEM_ARB_RR_EN
    logic w_unused_last;
    assign w_unused_last = i_last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between ICache miss and DCache fill/writeback paths.
// One transaction in flight; MEM_ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_line,
    output logic              i_data_rdy,
    input  logic              i_filled_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_line,
    output logic              d_data_rdy,
    input  logic              d_filled_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rline,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              owner
);

    arb_state_t        r_state, w_next;
    logic              r_owner, r_last_owner, r_we, r_cancel;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata, r_line;
    logic              w_gnt_vld, w_gnt_owner, w_own_req, w_own_ack;

    mem_arb_grant u_grant (
        .i_ireq       (i_req),
        .i_dreq       (d_req),
        .i_last_owner (r_last_owner),
        .o_vld        (w_gnt_vld),
        .o_owner      (w_gnt_owner)
    );

    assign w_own_req = (r_owner == OWNER_D) ? d_req : i_req;
    assign w_own_ack = (r_owner == OWNER_D) ? d_filled_ack : i_filled_ack;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ARB_IDLE;
        else       r_state <= w_next;
    end

    // A cancel seen on any MEM_WAIT cycle, including the mem_rdy cycle, drops the result.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:     if (w_gnt_vld) w_next = ARB_MEM_WAIT;
            ARB_MEM_WAIT: if (mem_rdy)
                              w_next = (r_cancel || !w_own_req) ? ARB_IDLE : ARB_DELIVER;
            ARB_DELIVER:  if (w_own_ack) w_next = ARB_IDLE;
            default:      w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWNER_I;
            r_last_owner <= OWNER_I;
            r_we         <= 1'b0;
            r_cancel     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: if (w_gnt_vld) begin
                    r_owner      <= w_gnt_owner;
                    r_last_owner <= w_gnt_owner;
                    r_addr       <= (w_gnt_owner == OWNER_D) ? d_addr : i_addr;
                    r_we         <= (w_gnt_owner == OWNER_D) && d_we;
                    r_wdata      <= (w_gnt_owner == OWNER_D) ? d_wdata : '0;
                    r_cancel     <= 1'b0;
                end
                ARB_MEM_WAIT: begin
                    if (!w_own_req) r_cancel <= 1'b1;
                    if (mem_rdy)    r_line   <= mem_rline;
                end
                default: ;
            endcase
        end
    end

    // Every output is a decode of registered state, so no input reaches an output combinationally.
    always_comb begin
        busy       = (r_state != ARB_IDLE);
        owner      = r_owner;
        mem_req    = (r_state == ARB_MEM_WAIT);
        mem_we     = r_we;
        mem_addr   = r_addr;
        mem_wdata  = r_wdata;
        i_line     = r_line;
        d_line     = r_line;
        i_data_rdy = (r_state == ARB_DELIVER) && (r_owner == OWNER_I);
        d_data_rdy = (r_state == ARB_DELIVER) && (r_owner == OWNER_D);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model checked every cycle plus literal checks.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = DEF_ADDR_W;
    localparam int LW = DEF_LINE_W;
    localparam logic [LW-1:0] LA5 = {(LW/8){8'hA5}};
    localparam logic [LW-1:0] L1  = {(LW/32){32'h1111_0001}};
    localparam logic [LW-1:0] L2  = {(LW/32){32'h2222_0002}};
    localparam logic [LW-1:0] L3  = {(LW/32){32'h3333_0003}};
    localparam logic [LW-1:0] L4  = {(LW/32){32'h4444_0004}};
    localparam logic [LW-1:0] L5  = {(LW/32){32'h5555_0005}};
    localparam logic [LW-1:0] L6  = {(LW/32){32'h6666_0006}};
    localparam logic [LW-1:0] WD  = {(LW/16){16'h1234}};

    logic clk = 1'b0, reset;
    logic i_req, i_filled_ack, d_req, d_we, d_filled_ack, mem_rdy;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, mem_rline;
    logic [LW-1:0] i_line, d_line, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic i_data_rdy, d_data_rdy, mem_req, mem_we, busy, owner;

    int  n_chk = 0, n_err = 0;
    bit  chk_en = 1'b0;
    bit  exp_tie2;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_line(i_line), .i_data_rdy(i_data_rdy),
        .i_filled_ack(i_filled_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_line(d_line),
        .d_data_rdy(d_data_rdy), .d_filled_ack(d_filled_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rline(mem_rline), .mem_rdy(mem_rdy), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one active transaction, either waiting on memory or delivering.
    bit            m_act, m_got, m_canc, m_owner, m_last, m_we;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_line;

    always @(posedge clk) begin : model
        bit w, oreq;
        if (reset) begin
            m_act <= 0; m_got <= 0; m_canc <= 0; m_owner <= 0; m_last <= 0; m_we <= 0;
            m_addr <= '0; m_wdata <= '0; m_line <= '0;
        end else if (!m_act) begin
            if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
                w = (i_req && d_req) ? !m_last : d_req;
`else
                w = d_req;
`endif
                m_act <= 1; m_got <= 0; m_canc <= 0; m_owner <= w; m_last <= w;
                m_addr  <= w ? d_addr : i_addr;
                m_we    <= w && d_we;
                m_wdata <= w ? d_wdata : '0;
            end
        end else if (!m_got) begin
            oreq = m_owner ? d_req : i_req;
            if (mem_rdy) begin
                m_line <= mem_rline;
                if (m_canc || !oreq) m_act <= 0;
                else                 m_got <= 1;
            end else if (!oreq) m_canc <= 1;
        end else if (m_owner ? d_filled_ack : i_filled_ack) begin
            m_act <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_act);
            chk("mem_req", mem_req, m_act && !m_got);
            chk("i_data_rdy", i_data_rdy, m_act && m_got && !m_owner);
            chk("d_data_rdy", d_data_rdy, m_act && m_got && m_owner);
            if (m_act) chk("owner", owner, m_owner);
            if (m_act && !m_got) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", mem_we, m_we);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_act && m_got && !m_owner) chk("i_line", i_line, m_line);
            if (m_act && m_got && m_owner && !m_we) chk("d_line", d_line, m_line);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic respond(input int dly, input logic [LW-1:0] line);
        for (int k = 0; k < 50 && !mem_req; k++) tick();
        chk("mem_req_timeout", mem_req, 1'b1);
        repeat (dly - 1) tick();
        mem_rdy = 1'b1; mem_rline = line;
        tick();
        mem_rdy = 1'b0; mem_rline = '0;
    endtask

    initial begin
        reset = 1; i_req = 0; i_addr = '0; i_filled_ack = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_filled_ack = 0;
        mem_rdy = 0; mem_rline = '0;
        tick(); tick();
        chk_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_i_line", i_line, '0);
        chk("rst_owner", owner, 1'b0);
        reset = 0;

        // I-fill, memory answers 5 cycles after mem_req
        i_req = 1; i_addr = 'h1040;
        tick();
        chk("ifill_mem_req", mem_req, 1'b1);
        chk("ifill_addr", mem_addr, 'h1040);
        chk("ifill_we", mem_we, 1'b0);
        repeat (4) tick();
        mem_rdy = 1; mem_rline = LA5;
        tick();
        mem_rdy = 0; mem_rline = '0;
        chk("ifill_rdy", i_data_rdy, 1'b1);
        chk("ifill_line", i_line, LA5);
        tick(); tick();
        chk("ifill_rdy_held", i_data_rdy, 1'b1);
        i_filled_ack = 1; i_req = 0;
        tick();
        i_filled_ack = 0;
        chk("ifill_idle", busy, 1'b0);

        // Tie: D first, then D again (fixed) or I (round-robin)
        i_req = 1; i_addr = 'h3000; d_req = 1; d_we = 0; d_addr = 'h300;
        tick();
        chk("tie1_owner", owner, 1'b1);
        chk("tie1_addr", mem_addr, 'h300);
        respond(2, L1);
        chk("tie1_drdy", d_data_rdy, 1'b1);
        chk("tie1_irdy", i_data_rdy, 1'b0);
        chk("tie1_line", d_line, L1);
        d_filled_ack = 1;
        tick();
        d_filled_ack = 0;
        chk("tie1_idle", busy, 1'b0);
        tick();
`ifdef MEM_ARB_RR_EN
        exp_tie2 = 1'b0;
`else
        exp_tie2 = 1'b1;
`endif
        chk("tie2_owner", owner, exp_tie2);
        chk("tie2_addr", mem_addr, exp_tie2 ? 'h300 : 'h3000);
        respond(3, L2);
        i_filled_ack = 1; d_filled_ack = 1; i_req = 0; d_req = 0;
        tick();
        i_filled_ack = 0; d_filled_ack = 0;
        chk("tie2_idle", busy, 1'b0);

        // D writeback, mem_rdy in the first MEM_WAIT cycle
        d_req = 1; d_we = 1; d_addr = 'h200; d_wdata = WD;
        tick();
        chk("wb_we", mem_we, 1'b1);
        chk("wb_wdata", mem_wdata, WD);
        chk("wb_addr", mem_addr, 'h200);
        respond(1, L3);
        chk("wb_drdy", d_data_rdy, 1'b1);
        chk("wb_irdy", i_data_rdy, 1'b0);
        d_filled_ack = 1; d_req = 0; d_we = 0;
        tick();
        d_filled_ack = 0;
        chk("wb_idle", busy, 1'b0);

        // Cancel two cycles into MEM_WAIT while D waits
        i_req = 1; i_addr = 'h2000;
        tick(); tick();
        i_req = 0; d_req = 1; d_addr = 'h400;
        tick(); tick();
        chk("cancel_hold", mem_req, 1'b1);
        mem_rdy = 1; mem_rline = L4;
        tick();
        mem_rdy = 0; mem_rline = '0;
        chk("cancel_idle", busy, 1'b0);
        chk("cancel_irdy", i_data_rdy, 1'b0);
        tick();
        chk("cancel_next_owner", owner, 1'b1);
        chk("cancel_next_addr", mem_addr, 'h400);
        respond(2, L5);
        chk("cancel_dline", d_line, L5);
        d_filled_ack = 1; d_req = 0;
        tick();
        d_filled_ack = 0;

        // Spurious mem_rdy in IDLE and ack in MEM_WAIT
        mem_rdy = 1; mem_rline = L4;
        tick();
        mem_rdy = 0; mem_rline = '0;
        chk("spur_idle", busy, 1'b0);
        chk("spur_irdy", i_data_rdy, 1'b0);
        chk("spur_drdy", d_data_rdy, 1'b0);
        i_req = 1; i_addr = 'h5000;
        tick();
        i_filled_ack = 1;
        tick();
        i_filled_ack = 0;
        chk("spur_ack_memreq", mem_req, 1'b1);
        chk("spur_ack_irdy", i_data_rdy, 1'b0);
        respond(1, L6);
        chk("spur_line", i_line, L6);
        i_filled_ack = 1; i_req = 0;
        tick();
        i_filled_ack = 0;

        // Reset in the middle of MEM_WAIT
        i_req = 1; i_addr = 'h6000;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0; i_req = 0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_memreq", mem_req, 1'b0);
        chk("rstmid_addr", mem_addr, '0);
        mem_rdy = 1; mem_rline = L1;
        tick();
        mem_rdy = 0; mem_rline = '0;
        chk("rstmid_late_rdy", busy, 1'b0);
        chk("rstmid_irdy", i_data_rdy, 1'b0);
        i_req = 1; i_addr = 'h7000;
        tick();
        chk("rstmid_new_addr", mem_addr, 'h7000);
        respond(3, LA5);
        chk("rstmid_new_line", i_line, LA5);
        i_filled_ack = 1; i_req = 0;
        tick();
        i_filled_ack = 0;
        chk("rstmid_final_idle", busy, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
